// File: rtl/ahblite_sram_gpio_sys.sv
// ahblite_sram_gpio_sys
//
// AHB-Lite slave subsystem sitting directly below the CPU master port.
// An address decoder on HADDR[31:24] routes each transfer to one of three
// slaves, and a registered select steers the data-phase response mux:
//   0x20xx_xxxx : SRAM bridge to four external synchronous SRAM banks
//   0x48xx_xxxx : 16-bit GPIO register block
//   others      : default slave (reads 0, writes ignored, no wait states)
//
// Ports
//   HCLK, HRESETn              clock, asynchronous active-low reset
//   HADDR/HWRITE/HTRANS/HSIZE  address-phase controls from the master
//   HWDATA                     data-phase write data
//   HREADY, HRDATA             muxed slave response (HREADY is also fed back
//                              as the slaves' HREADY input)
//   SRAMRDATA                  SRAM read data, one clock after address/CS
//   SRAMADDR, SRAMWDATA,
//   SRAMWEN, SRAMCS0..3        SRAM pins (word address, data, lane enables,
//                              per-bank chip selects, all active-high)
//   GPIOIN                     pad inputs
//   GPIOOUT, GPIOPU, GPIOPD    pad output value, pull-up, pull-down enables
//   GPIOOEN                    pad output enable, active-low (~DIR)
module ahblite_sram_gpio_sys (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    output logic        HREADY,
    output logic [31:0] HRDATA,
    input  logic [31:0] SRAMRDATA,
    output logic [3:0]  SRAMWEN,
    output logic [31:0] SRAMWDATA,
    output logic        SRAMCS0,
    output logic        SRAMCS1,
    output logic        SRAMCS2,
    output logic        SRAMCS3,
    output logic [14:0] SRAMADDR,
    input  logic [15:0] GPIOIN,
    output logic [15:0] GPIOOUT,
    output logic [15:0] GPIOPU,
    output logic [15:0] GPIOPD,
    output logic [15:0] GPIOOEN
);

    typedef enum logic [1:0] {
        SEL_DEF  = 2'd0,
        SEL_SRAM = 2'd1,
        SEL_GPIO = 2'd2
    } sel_e;

    // ---------------- address phase decode ----------------
    logic trans_act;
    logic hit_sram;
    logic hit_gpio;
    sel_e sel_d;
    sel_e sel_q;

    assign trans_act = HTRANS[1] & HREADY;
    assign hit_sram  = (HADDR[31:24] == 8'h20);
    assign hit_gpio  = (HADDR[31:24] == 8'h48);

    always_comb begin
        sel_d = SEL_DEF;
        if (trans_act && hit_sram)      sel_d = SEL_SRAM;
        else if (trans_act && hit_gpio) sel_d = SEL_GPIO;
    end

    // HADDR[23:19] lies outside every decoded field.
    logic unused_haddr;
    assign unused_haddr = ^HADDR[23:19];

    // ---------------- SRAM bridge ----------------
    logic        sram_wr_a;     // SRAM write address phase
    logic        sram_rd_a;     // SRAM read address phase
    logic        collide_a;     // read address phase while a write owns the port
    logic [3:0]  lanes_a;

    logic        wr_pend_q;     // high during a write's data phase
    logic [14:0] wr_addr_q;
    logic [1:0]  wr_bank_q;
    logic [3:0]  wr_lanes_q;

    logic        rd_hold_q;     // first data-phase cycle of a collided read
    logic [14:0] rd_addr_q;
    logic [1:0]  rd_bank_q;

    logic [14:0] sram_addr_d, sram_addr_q;
    logic [31:0] sram_wdata_d, sram_wdata_q;
    logic [3:0]  sram_cs_d;
    logic [3:0]  sram_wen_d;

    assign sram_wr_a = trans_act & hit_sram & HWRITE;
    assign sram_rd_a = trans_act & hit_sram & ~HWRITE;
    assign collide_a = sram_rd_a & wr_pend_q;

    always_comb begin
        lanes_a = 4'b1111;
        case (HSIZE)
            3'd0:    lanes_a = 4'b0001 << HADDR[1:0];
            3'd1:    lanes_a = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes_a = 4'b1111;
        endcase
    end

    // Port arbitration: a write in its data phase owns the port; a collided
    // read re-issues its saved address next; otherwise a fresh read is
    // presented straight from HADDR. Address and write data hold when idle.
    always_comb begin
        sram_cs_d    = 4'b0000;
        sram_wen_d   = 4'b0000;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        if (wr_pend_q) begin
            sram_cs_d    = 4'b0001 << wr_bank_q;
            sram_addr_d  = wr_addr_q;
            sram_wen_d   = wr_lanes_q;
            sram_wdata_d = HWDATA;
        end else if (rd_hold_q) begin
            sram_cs_d   = 4'b0001 << rd_bank_q;
            sram_addr_d = rd_addr_q;
        end else if (sram_rd_a) begin
            sram_cs_d   = 4'b0001 << HADDR[18:17];
            sram_addr_d = HADDR[16:2];
        end
    end

    assign SRAMADDR  = sram_addr_d;
    assign SRAMWDATA = sram_wdata_d;
    assign SRAMWEN   = sram_wen_d;
    assign SRAMCS0   = sram_cs_d[0];
    assign SRAMCS1   = sram_cs_d[1];
    assign SRAMCS2   = sram_cs_d[2];
    assign SRAMCS3   = sram_cs_d[3];

    // ---------------- GPIO block ----------------
    logic [15:0] datain_q, dataout_q, pu_q, pd_q, dir_q;
    logic        gp_wr_q;
    logic [2:0]  gp_off_q;
    logic [15:0] gp_rdata;

    always_comb begin
        gp_rdata = 16'h0000;
        case (gp_off_q)
            3'd0:    gp_rdata = datain_q;
            3'd1:    gp_rdata = dataout_q;
            3'd2:    gp_rdata = pu_q;
            3'd3:    gp_rdata = pd_q;
            3'd4:    gp_rdata = dir_q;
            default: gp_rdata = 16'h0000;
        endcase
    end

    assign GPIOOUT = dataout_q;
    assign GPIOPU  = pu_q;
    assign GPIOPD  = pd_q;
    assign GPIOOEN = ~dir_q;

    // ---------------- response mux ----------------
    always_comb begin
        HREADY = 1'b1;
        HRDATA = 32'h0000_0000;
        case (sel_q)
            SEL_SRAM: begin
                HREADY = ~rd_hold_q;
                HRDATA = SRAMRDATA;
            end
            SEL_GPIO: HRDATA = {16'h0000, gp_rdata};
            default:  ;
        endcase
    end

    // ---------------- state ----------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q        <= SEL_DEF;
            wr_pend_q    <= 1'b0;
            wr_addr_q    <= 15'd0;
            wr_bank_q    <= 2'd0;
            wr_lanes_q   <= 4'd0;
            rd_hold_q    <= 1'b0;
            rd_addr_q    <= 15'd0;
            rd_bank_q    <= 2'd0;
            sram_addr_q  <= 15'd0;
            sram_wdata_q <= 32'd0;
            datain_q     <= 16'd0;
            dataout_q    <= 16'd0;
            pu_q         <= 16'd0;
            pd_q         <= 16'd0;
            dir_q        <= 16'd0;
            gp_wr_q      <= 1'b0;
            gp_off_q     <= 3'd0;
        end else begin
            if (HREADY) sel_q <= sel_d;

            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;

            wr_pend_q <= sram_wr_a;
            if (sram_wr_a) begin
                wr_addr_q  <= HADDR[16:2];
                wr_bank_q  <= HADDR[18:17];
                wr_lanes_q <= lanes_a;
            end

            rd_hold_q <= collide_a;
            if (collide_a) begin
                rd_addr_q <= HADDR[16:2];
                rd_bank_q <= HADDR[18:17];
            end

            datain_q <= GPIOIN;
            gp_wr_q  <= trans_act & hit_gpio & HWRITE;
            if (trans_act && hit_gpio) gp_off_q <= HADDR[4:2];
            // Writes land on the edge that ends the data phase; HSIZE is ignored.
            if (gp_wr_q && HREADY) begin
                case (gp_off_q)
                    3'd1:    dataout_q <= HWDATA[15:0];
                    3'd2:    pu_q      <= HWDATA[15:0];
                    3'd3:    pd_q      <= HWDATA[15:0];
                    3'd4:    dir_q     <= HWDATA[15:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ahblite_sram_gpio_sys.sv
module tb_ahblite_sram_gpio_sys;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic [31:0] SRAMRDATA;
    logic [3:0]  SRAMWEN;
    logic [31:0] SRAMWDATA;
    logic        SRAMCS0, SRAMCS1, SRAMCS2, SRAMCS3;
    logic [14:0] SRAMADDR;
    logic [15:0] GPIOIN;
    logic [15:0] GPIOOUT, GPIOPU, GPIOPD, GPIOOEN;

    ahblite_sram_gpio_sys dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .SRAMRDATA (SRAMRDATA),
        .SRAMWEN   (SRAMWEN),
        .SRAMWDATA (SRAMWDATA),
        .SRAMCS0   (SRAMCS0),
        .SRAMCS1   (SRAMCS1),
        .SRAMCS2   (SRAMCS2),
        .SRAMCS3   (SRAMCS3),
        .SRAMADDR  (SRAMADDR),
        .GPIOIN    (GPIOIN),
        .GPIOOUT   (GPIOOUT),
        .GPIOPU    (GPIOPU),
        .GPIOPD    (GPIOPD),
        .GPIOOEN   (GPIOOEN)
    );

    always #5 HCLK = ~HCLK;

    // ---------------- external synchronous SRAM (4 banks) ----------------
    logic [3:0]  cs_vec;
    logic [1:0]  bank;
    bit   [31:0] mem [0:131071];

    assign cs_vec = {SRAMCS3, SRAMCS2, SRAMCS1, SRAMCS0};

    always_comb begin
        bank = 2'd0;
        case (cs_vec)
            4'b0010: bank = 2'd1;
            4'b0100: bank = 2'd2;
            4'b1000: bank = 2'd3;
            default: bank = 2'd0;
        endcase
    end

    initial SRAMRDATA = 32'h0;

    always @(posedge HCLK) begin
        if (cs_vec != 4'h0) begin
            if (SRAMWEN != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (SRAMWEN[b]) mem[{bank, SRAMADDR}][8*b +: 8] <= SRAMWDATA[8*b +: 8];
            end else begin
                SRAMRDATA <= mem[{bank, SRAMADDR}];
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    // One row per clock: address-phase inputs, data-phase HWDATA and GPIOIN,
    // plus the outputs expected mid-cycle. mask selects which outputs matter.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        write;
        logic [1:0]  trans;
        logic [2:0]  size;
        logic [15:0] gpin;
        logic [8:0]  mask;
        logic        rdy;
        logic [31:0] rdata;
        logic [3:0]  cs;
        logic [14:0] saddr;
        logic [3:0]  wen;
        logic [31:0] swdata;
        logic [15:0] gout;
        logic [15:0] goen;
        logic [15:0] pu;
        logic [15:0] pd;
    } vec_t;

    vec_t vecs[$];

    localparam logic [8:0] MR = 9'h001;  // HREADY
    localparam logic [8:0] MD = 9'h002;  // HRDATA
    localparam logic [8:0] MC = 9'h004;  // chip selects
    localparam logic [8:0] MA = 9'h008;  // SRAMADDR
    localparam logic [8:0] MW = 9'h010;  // SRAMWEN
    localparam logic [8:0] MS = 9'h020;  // SRAMWDATA
    localparam logic [8:0] MO = 9'h040;  // GPIOOUT
    localparam logic [8:0] ME = 9'h080;  // GPIOOEN
    localparam logic [8:0] MP = 9'h100;  // GPIOPU / GPIOPD

    localparam logic [1:0] ID = 2'd0;
    localparam logic [1:0] BZ = 2'd1;
    localparam logic [1:0] NS = 2'd2;
    localparam logic [2:0] SB = 3'd0;
    localparam logic [2:0] SH = 3'd1;
    localparam logic [2:0] SW = 3'd2;

    task automatic addv(input logic [31:0] a, input logic [31:0] wd, input logic w,
                        input logic [1:0] t, input logic [2:0] s, input logic [15:0] gi,
                        input logic [8:0] m, input logic rdy, input logic [31:0] rd,
                        input logic [3:0] cs, input logic [14:0] sa, input logic [3:0] wen,
                        input logic [31:0] swd, input logic [15:0] go, input logic [15:0] oe,
                        input logic [15:0] pu, input logic [15:0] pd);
        vec_t v;
        v.addr = a; v.wdata = wd; v.write = w; v.trans = t; v.size = s; v.gpin = gi;
        v.mask = m; v.rdy = rdy; v.rdata = rd; v.cs = cs; v.saddr = sa; v.wen = wen;
        v.swdata = swd; v.gout = go; v.goen = oe; v.pu = pu; v.pd = pd;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        HADDR  = 32'h0;
        HWDATA = 32'h0;
        HWRITE = 1'b0;
        HTRANS = ID;
        HSIZE  = SW;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //        addr          wdata         wr    tr  sz  gpin      mask              rdy   rdata         cs     saddr   wen    swdata        gout      goen      pu        pd
        // after reset: read DIR
        addv(32'h48000010, 32'h00000000, 1'b0, NS, SW, 16'h0000, MR|MC|MW|ME,      1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
        addv(32'h00000000, 32'h00000000, 1'b0, ID, SW, 16'h0000, MR|MD,            1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // SRAM word write, idle, read back
        addv(32'h20000004, 32'h00000000, 1'b1, NS, SW, 16'h0000, MR|MC|MW|MA|MS,   1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h00000000, 32'h12345678, 1'b0, ID, SW, 16'h0000, MR|MC|MA|MW|MS,   1'b1, 32'h00000000, 4'h1, 15'd1, 4'hF, 32'h12345678, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h20000004, 32'h00000000, 1'b0, NS, SW, 16'h0000, MR|MC|MA|MW|MS,   1'b1, 32'h00000000, 4'h1, 15'd1, 4'h0, 32'h12345678, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h00000000, 32'h00000000, 1'b0, ID, SW, 16'h0000, MR|MD|MC|MW|MA,   1'b1, 32'h12345678, 4'h0, 15'd1, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // SRAM byte write to bank 3, lane 3
        addv(32'h20060003, 32'h00000000, 1'b1, NS, SB, 16'h0000, MR|MC,            1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h00000000, 32'hAA000000, 1'b0, ID, SW, 16'h0000, MR|MC|MA|MW|MS,   1'b1, 32'h00000000, 4'h8, 15'd0, 4'h8, 32'hAA000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // write then immediate read of the same word: one wait state
        addv(32'h20000008, 32'h00000000, 1'b1, NS, SW, 16'h0000, MR|MC|MW|MA|MS,   1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'hAA000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h20000008, 32'hCAFEF00D, 1'b0, NS, SW, 16'h0000, MR|MC|MA|MW|MS,   1'b1, 32'h00000000, 4'h1, 15'd2, 4'hF, 32'hCAFEF00D, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h20000004, 32'h00000000, 1'b0, NS, SW, 16'h0000, MR|MC|MA|MW,      1'b0, 32'h00000000, 4'h1, 15'd2, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h20000004, 32'h00000000, 1'b0, NS, SW, 16'h0000, MR|MD|MC|MA|MW,   1'b1, 32'hCAFEF00D, 4'h1, 15'd1, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h00000000, 32'h00000000, 1'b0, ID, SW, 16'h0000, MR|MD|MC,         1'b1, 32'h12345678, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // read back the byte-written word: only lane 3 was touched
        addv(32'h20060000, 32'h00000000, 1'b0, NS, SW, 16'h0000, MR|MC|MA,         1'b1, 32'h00000000, 4'h8, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h00000000, 32'h00000000, 1'b0, ID, SW, 16'h0000, MR|MD,            1'b1, 32'hAA000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // GPIO back-to-back writes: DIR, DATAOUT, PU, PD, unmapped offset
        addv(32'h48000010, 32'h00000000, 1'b1, NS, SW, 16'h0000, MR|MC|ME,         1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
        addv(32'h48000004, 32'hFFFF00FF, 1'b1, NS, SW, 16'h0000, MR|MO|ME,         1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
        addv(32'h48000008, 32'h00005A5A, 1'b1, NS, SW, 16'h0000, MR|MO|ME,         1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'hFF00, 16'h0000, 16'h0000);
        addv(32'h4800000C, 32'h00001234, 1'b1, NS, SW, 16'h0000, MR|MO|ME|MP,      1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h5A5A, 16'hFF00, 16'h0000, 16'h0000);
        addv(32'h48000014, 32'h0000C3C3, 1'b1, NS, SB, 16'h0000, MR|MP|MW|MC,      1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h1234, 16'h0000);
        addv(32'h4800000C, 32'hFFFFFFFF, 1'b0, NS, SW, 16'hBEEF, MR|MP|MO|ME,      1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h5A5A, 16'hFF00, 16'h1234, 16'hC3C3);
        // GPIO reads: PD, unmapped offset, DATAIN (one clock stale), DIR
        addv(32'h48000014, 32'h00000000, 1'b0, NS, SW, 16'hBEEF, MR|MD,            1'b1, 32'h0000C3C3, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h48000000, 32'h00000000, 1'b0, NS, SW, 16'hBEEF, MR|MD,            1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h48000010, 32'h00000000, 1'b0, NS, SW, 16'h1111, MR|MD,            1'b1, 32'h0000BEEF, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // unmapped read and write
        addv(32'h30000000, 32'h00000000, 1'b0, NS, SW, 16'h1111, MR|MD|MC,         1'b1, 32'h000000FF, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h30000000, 32'h00000000, 1'b1, NS, SW, 16'h1111, MR|MD|MC|MW,      1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h48000000, 32'hDEADBEEF, 1'b0, NS, SW, 16'h1111, MR|MD|MC|MW|MO,   1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h5A5A, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h00000000, 32'h00000000, 1'b0, ID, SW, 16'h1111, MR|MD,            1'b1, 32'h00001111, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // BUSY write to SRAM must not produce a write
        addv(32'h20000000, 32'h00000000, 1'b1, BZ, SW, 16'h1111, MR|MC|MW,         1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h00000000, 32'h12121212, 1'b0, ID, SW, 16'h1111, MR|MC|MW|MA|MS,   1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'hCAFEF00D, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // halfword write to upper lanes, then read merged word
        addv(32'h20000006, 32'h00000000, 1'b1, NS, SH, 16'h1111, MR|MC|MW,         1'b1, 32'h00000000, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h00000000, 32'hBBBB0000, 1'b0, ID, SW, 16'h1111, MR|MC|MA|MW|MS,   1'b1, 32'h00000000, 4'h1, 15'd1, 4'hC, 32'hBBBB0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h20000004, 32'h00000000, 1'b0, NS, SW, 16'h1111, MR|MC|MA|MW,      1'b1, 32'h00000000, 4'h1, 15'd1, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        addv(32'h00000000, 32'h00000000, 1'b0, ID, SW, 16'h1111, MR|MD|MC,         1'b1, 32'hBBBB5678, 4'h0, 15'd0, 4'h0, 32'h00000000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        // ---------------- reset state ----------------
        HRESETn = 1'b0;
        GPIOIN  = 16'h0000;
        idle_inputs();
        repeat (2) @(negedge HCLK);
        chk("rst.hready",    {31'b0, HREADY}, 32'h1);
        chk("rst.hrdata",    HRDATA, 32'h0);
        chk("rst.sramwen",   {28'b0, SRAMWEN}, 32'h0);
        chk("rst.sramcs",    {28'b0, cs_vec}, 32'h0);
        chk("rst.sramaddr",  {17'b0, SRAMADDR}, 32'h0);
        chk("rst.sramwdata", SRAMWDATA, 32'h0);
        chk("rst.gpiooen",   {16'b0, GPIOOEN}, 32'h0000FFFF);
        chk("rst.gpioout",   {16'b0, GPIOOUT}, 32'h0);
        chk("rst.gpiopu",    {16'b0, GPIOPU}, 32'h0);
        chk("rst.gpiopd",    {16'b0, GPIOPD}, 32'h0);
        HRESETn = 1'b1;

        // ---------------- table-driven cycles ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge HCLK);
            #1;
            HADDR  = vecs[i].addr;
            HWDATA = vecs[i].wdata;
            HWRITE = vecs[i].write;
            HTRANS = vecs[i].trans;
            HSIZE  = vecs[i].size;
            GPIOIN = vecs[i].gpin;
            @(negedge HCLK);
            $display("vec %0d: addr=%08h tr=%0d wr=%0b hwdata=%08h -> hready=%0b hrdata=%08h cs=%h saddr=%0d wen=%h",
                     i, HADDR, HTRANS, HWRITE, HWDATA, HREADY, HRDATA, cs_vec, SRAMADDR, SRAMWEN);
            if (vecs[i].mask[0]) chk($sformatf("v%0d.hready", i),    {31'b0, HREADY}, {31'b0, vecs[i].rdy});
            if (vecs[i].mask[1]) chk($sformatf("v%0d.hrdata", i),    HRDATA, vecs[i].rdata);
            if (vecs[i].mask[2]) chk($sformatf("v%0d.sramcs", i),    {28'b0, cs_vec}, {28'b0, vecs[i].cs});
            if (vecs[i].mask[3]) chk($sformatf("v%0d.sramaddr", i),  {17'b0, SRAMADDR}, {17'b0, vecs[i].saddr});
            if (vecs[i].mask[4]) chk($sformatf("v%0d.sramwen", i),   {28'b0, SRAMWEN}, {28'b0, vecs[i].wen});
            if (vecs[i].mask[5]) chk($sformatf("v%0d.sramwdata", i), SRAMWDATA, vecs[i].swdata);
            if (vecs[i].mask[6]) chk($sformatf("v%0d.gpioout", i),   {16'b0, GPIOOUT}, {16'b0, vecs[i].gout});
            if (vecs[i].mask[7]) chk($sformatf("v%0d.gpiooen", i),   {16'b0, GPIOOEN}, {16'b0, vecs[i].goen});
            if (vecs[i].mask[8]) begin
                chk($sformatf("v%0d.gpiopu", i), {16'b0, GPIOPU}, {16'b0, vecs[i].pu});
                chk($sformatf("v%0d.gpiopd", i), {16'b0, GPIOPD}, {16'b0, vecs[i].pd});
            end
        end

        // ---------------- reset during a write data phase ----------------
        @(posedge HCLK);
        #1;
        HADDR  = 32'h2000000C;
        HWRITE = 1'b1;
        HTRANS = NS;
        HSIZE  = SW;
        @(posedge HCLK);
        #1;
        idle_inputs();
        HWDATA = 32'h55555555;
        #1;
        $display("midrst: data phase before reset wen=%h cs=%h", SRAMWEN, cs_vec);
        chk("midrst.wen_before", {28'b0, SRAMWEN}, 32'hF);
        chk("midrst.cs_before",  {28'b0, cs_vec}, 32'h1);
        HRESETn = 1'b0;
        #1;
        $display("midrst: reset asserted wen=%h cs=%h hready=%0b", SRAMWEN, cs_vec, HREADY);
        chk("midrst.wen",     {28'b0, SRAMWEN}, 32'h0);
        chk("midrst.cs",      {28'b0, cs_vec}, 32'h0);
        chk("midrst.hready",  {31'b0, HREADY}, 32'h1);
        chk("midrst.addr",    {17'b0, SRAMADDR}, 32'h0);
        chk("midrst.wdata",   SRAMWDATA, 32'h0);
        chk("midrst.gpiooen", {16'b0, GPIOOEN}, 32'h0000FFFF);
        chk("midrst.gpioout", {16'b0, GPIOOUT}, 32'h0);
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        HADDR  = 32'h2000000C;
        HWRITE = 1'b0;
        HTRANS = NS;
        HSIZE  = SW;
        @(posedge HCLK);
        #1;
        idle_inputs();
        @(negedge HCLK);
        $display("midrst: read back 2000000C hrdata=%08h hready=%0b", HRDATA, HREADY);
        chk("midrst.readback", HRDATA, 32'h0);
        chk("midrst.rb_ready", {31'b0, HREADY}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
